// File: rtl/rfwrite_trace_queue_pkg.sv
// rfwrite_trace_queue_pkg
//   Shared types for the register-file write trace path.
//   rf_w_t      : one register-file write record {wen, addr, wd}
//   word_t      : 32-bit machine word
//   creg_addr_t : 5-bit GPR index
//   lane_cnt_t  : wide enough to hold 0..RFWQ_MAX_LANES
package rfwrite_trace_queue_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;

    typedef struct packed {
        logic       wen;
        creg_addr_t addr;
        word_t      wd;
    } rf_w_t;

    localparam int unsigned RFWQ_MAX_LANES = 4;
    localparam int unsigned RFWQ_CNT_W     = $clog2(RFWQ_MAX_LANES + 1);

    typedef logic [RFWQ_CNT_W-1:0] lane_cnt_t;

endpackage

// File: rtl/rfwrite_trace_queue_if.sv
// rfwrite_trace_queue_if
//   Retire-side enqueue bus and trace-side valid/ready drain bus.
//   rfw/rt_pc : per-lane write records and PCs (lane IN_LANES-1 oldest)
//   in_ready  : at least IN_LANES free entries (advisory)
//   out_*     : first-word-fall-through head of the queue
//   slave     : queue view; master : producer/consumer view
interface rfwrite_trace_queue_if
    import rfwrite_trace_queue_pkg::*;
#(
    parameter int unsigned IN_LANES = 2
) ();

    rf_w_t [IN_LANES-1:0] rfw;
    word_t [IN_LANES-1:0] rt_pc;
    logic                 in_ready;
    logic                 out_valid;
    rf_w_t                out_rfw;
    word_t                out_pc;
    logic                 out_ready;

    modport master (
        output rfw, rt_pc, out_ready,
        input  in_ready, out_valid, out_rfw, out_pc
    );

    modport slave (
        input  rfw, rt_pc, out_ready,
        output in_ready, out_valid, out_rfw, out_pc
    );

endinterface

// File: rtl/rfwrite_trace_queue_compactor.sv
// rfwq_lane_compactor
//   Combinational prefix count over the lane enable vector, oldest lane
//   (highest index) first.
//   wen_i      : per-lane effective write enable
//   slot_off_o : per-lane slot offset from tail (valid where wen_i=1)
//   n_o        : number of enabled lanes
module rfwq_lane_compactor
    import rfwrite_trace_queue_pkg::*;
#(
    parameter int unsigned IN_LANES = 2
) (
    input  logic      [IN_LANES-1:0] wen_i,
    output lane_cnt_t [IN_LANES-1:0] slot_off_o,
    output lane_cnt_t                n_o
);

    lane_cnt_t acc;

    always_comb begin
        slot_off_o = '0;
        acc        = '0;
        for (int unsigned k = 0; k < IN_LANES; k++) begin
            slot_off_o[IN_LANES-1-k] = acc;
            acc = acc + lane_cnt_t'(wen_i[IN_LANES-1-k]);
        end
        n_o = acc;
    end

endmodule

// File: rtl/rfwrite_trace_queue.sv
// rfwrite_trace_queue
//   Collects up to IN_LANES retired register writes per cycle and drains
//   them one per cycle in program order. Groups that do not fit are
//   dropped whole and accounted in overflow/drop_cnt.
//   clk, reset : clock, synchronous active-low reset
//   bus        : enqueue lanes + FWFT valid/ready head (slave modport)
//   count      : occupancy
//   overflow   : sticky, some group was dropped since reset
//   drop_cnt   : dropped records, saturating
//   Build option RFWQ_SKIP_R0_EN: writes to $0 are ignored at the input.
module rfwrite_trace_queue
    import rfwrite_trace_queue_pkg::*;
#(
    parameter int unsigned IN_LANES = 2,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned DROP_W   = 16,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    rfwrite_trace_queue_if.slave  bus,
    output logic [CW-1:0]         count,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [DROP_W:0]   drop_sum;

    rf_w_t             mem_q [DEPTH];
    word_t             pc_q  [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    logic [IN_LANES-1:0]     wen;
    lane_cnt_t [IN_LANES-1:0] slot_off;
    lane_cnt_t               n;
    logic [PW-1:0]           slot_idx [IN_LANES];
    logic [CW-1:0]           free;
    logic                    accept, drop, pop, head_live;

    always_comb begin
        for (int unsigned i = 0; i < IN_LANES; i++) begin
`ifdef RFWQ_SKIP_R0_EN
            wen[i] = bus.rfw[i].wen && (bus.rfw[i].addr != '0);
`else
            wen[i] = bus.rfw[i].wen;
`endif
        end
    end

    rfwq_lane_compactor #(.IN_LANES(IN_LANES)) u_compactor (
        .wen_i      (wen),
        .slot_off_o (slot_off),
        .n_o        (n)
    );

    always_comb begin
        for (int unsigned i = 0; i < IN_LANES; i++) begin
            slot_idx[i] = tail_q + PW'(slot_off[i]);
        end
    end

    // Space check uses pre-pop occupancy: a same-cycle pop never makes room.
    always_comb begin
        free       = CW'(DEPTH) - count_q;
        accept     = (n != '0) && (32'(n) <= 32'(free));
        drop       = (n != '0) && !accept;
        pop        = (count_q != '0) && bus.out_ready;

        tail_d     = accept ? tail_q + PW'(n) : tail_q;
        head_d     = pop ? head_q + PW'(1) : head_q;
        count_d    = count_q;
        if (accept) count_d = count_d + CW'(n);
        if (pop)    count_d = count_d - CW'(1);

        overflow_d = overflow_q | drop;
        drop_sum   = {1'b0, drop_q} + (DROP_W+1)'(n);
        drop_d     = drop_q;
        if (drop) drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            vld_q      <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            // Pushed slots are always free, so they never alias the popped head.
            if (pop) vld_q[head_q] <= 1'b0;
            for (int unsigned i = 0; i < IN_LANES; i++) begin
                if (accept && wen[i]) vld_q[slot_idx[i]] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && accept) begin
            for (int unsigned i = 0; i < IN_LANES; i++) begin
                if (wen[i]) begin
                    mem_q[slot_idx[i]] <= bus.rfw[i];
                    pc_q[slot_idx[i]]  <= bus.rt_pc[i];
                end
            end
        end
    end

    assign head_live     = (count_q != '0) && vld_q[head_q];
    assign bus.out_valid = (count_q != '0);
    assign bus.out_rfw   = head_live ? mem_q[head_q] : '0;
    assign bus.out_pc    = head_live ? pc_q[head_q]  : '0;
    assign bus.in_ready  = (32'(free) >= IN_LANES);

    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_rfwrite_trace_queue.sv
module tb_rfwrite_trace_queue;
    import rfwrite_trace_queue_pkg::*;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    rf_w_t exp_rf [$];
    word_t exp_pc [$];

    rfwrite_trace_queue_if #(.IN_LANES(2)) bus ();

    rfwrite_trace_queue #(.IN_LANES(2), .DEPTH(DEPTH), .DROP_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic rf_w_t mk(input creg_addr_t a, input word_t d);
        mk = '{wen: 1'b1, addr: a, wd: d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input rf_w_t r1, input word_t p1, input rf_w_t r0, input word_t p0);
        bus.rfw[1]   = r1;
        bus.rt_pc[1] = p1;
        bus.rfw[0]   = r0;
        bus.rt_pc[0] = p0;
    endtask

    task automatic idle();
        drive('0, '0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcvd, cyc, guard;
        logic rdy, over64;
        rf_w_t r;

        reset = 1'b0;
        bus.out_ready = 1'b0;
        idle();
        tick();
        tick();

        // reset state
        chk("rst_valid",    64'(bus.out_valid), 64'(0));
        chk("rst_rfw",      64'(bus.out_rfw),   64'(0));
        chk("rst_pc",       64'(bus.out_pc),    64'(0));
        chk("rst_in_ready", 64'(bus.in_ready),  64'(1));
        chk("rst_count",    64'(count),         64'(0));
        chk("rst_overflow", 64'(overflow),      64'(0));
        chk("rst_drop",     64'(drop_cnt),      64'(0));

        // dual-lane push, oldest lane (1) drains first
        reset = 1'b1;
        bus.out_ready = 1'b1;
        drive(mk(5'd5, 32'hA), 32'h100, mk(5'd6, 32'hB), 32'h104);
        tick();
        idle();
        chk("dual_count0", 64'(count),       64'(2));
        chk("dual_rfw0",   64'(bus.out_rfw), 64'(mk(5'd5, 32'hA)));
        chk("dual_pc0",    64'(bus.out_pc),  64'(32'h100));
        tick();
        chk("dual_count1", 64'(count),       64'(1));
        chk("dual_rfw1",   64'(bus.out_rfw), 64'(mk(5'd6, 32'hB)));
        chk("dual_pc1",    64'(bus.out_pc),  64'(32'h104));
        tick();
        chk("dual_empty_valid", 64'(bus.out_valid), 64'(0));
        chk("dual_empty_count", 64'(count),         64'(0));
        chk("dual_empty_rfw",   64'(bus.out_rfw),   64'(0));

        // single lanes on consecutive cycles, held then drained
        bus.out_ready = 1'b0;
        drive('0, '0, mk(5'd7, 32'h11), 32'h200);
        tick();
        drive(mk(5'd8, 32'h22), 32'h204, '0, '0);
        tick();
        idle();
        chk("mix_count", 64'(count),       64'(2));
        chk("mix_rfw0",  64'(bus.out_rfw), 64'(mk(5'd7, 32'h11)));
        chk("mix_pc0",   64'(bus.out_pc),  64'(32'h200));
        bus.out_ready = 1'b1;
        tick();
        chk("mix_rfw1",  64'(bus.out_rfw), 64'(mk(5'd8, 32'h22)));
        chk("mix_pc1",   64'(bus.out_pc),  64'(32'h204));
        tick();
        chk("mix_empty", 64'(bus.out_valid), 64'(0));
        bus.out_ready = 1'b0;

        // fill: entry k holds wd=k, pc=0x1000+4k, addr=(k/2)%31+1
        for (int i = 0; i < 32; i++) begin
            drive(mk(5'((i % 31) + 1), 32'(2 * i)),     32'(32'h1000 + 8 * i),
                  mk(5'((i % 31) + 1), 32'(2 * i + 1)), 32'(32'h1000 + 8 * i + 4));
            if (i == 31) chk("fill_in_ready_62", 64'(bus.in_ready), 64'(1));
            tick();
        end
        idle();
        chk("full_count",    64'(count),        64'(64));
        chk("full_in_ready", 64'(bus.in_ready), 64'(0));
        chk("full_overflow", 64'(overflow),     64'(0));

        drive(mk(5'd9, 32'hDEAD), 32'h5000, mk(5'd10, 32'hBEEF), 32'h5004);
        tick();
        idle();
        chk("drop_count",    64'(count),       64'(64));
        chk("drop_overflow", 64'(overflow),    64'(1));
        chk("drop_cnt1",     64'(drop_cnt),    64'(2));
        chk("drop_head_rfw", 64'(bus.out_rfw), 64'(mk(5'd1, 32'd0)));
        chk("drop_head_pc",  64'(bus.out_pc),  64'(32'h1000));

        // full + pop + push: pop succeeds, push dropped
        bus.out_ready = 1'b1;
        drive(mk(5'd9, 32'hDEAD), 32'h5000, mk(5'd10, 32'hBEEF), 32'h5004);
        tick();
        idle();
        bus.out_ready = 1'b0;
        chk("popdrop_count", 64'(count),       64'(63));
        chk("popdrop_drop",  64'(drop_cnt),    64'(4));
        chk("popdrop_rfw",   64'(bus.out_rfw), 64'(mk(5'd1, 32'd1)));
        chk("popdrop_pc",    64'(bus.out_pc),  64'(32'h1004));

        bus.out_ready = 1'b1;
        for (int k = 1; k < 64; k++) begin
            chk("drain_rfw", 64'(bus.out_rfw), 64'(mk(5'(((k / 2) % 31) + 1), 32'(k))));
            chk("drain_pc",  64'(bus.out_pc),  64'(32'(32'h1000 + 4 * k)));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("drain_count", 64'(count),         64'(0));
        chk("drain_valid", 64'(bus.out_valid), 64'(0));

        // wrap: 200 single-lane records, toggling ready, random gaps
        sent = 0; rcvd = 0; cyc = 0; rdy = 1'b0; over64 = 1'b0;
        while (rcvd < 200 && cyc < 3000) begin
            if (count > 7'd64) over64 = 1'b1;
            rdy = ~rdy;
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                if (exp_rf.size() == 0) begin
                    chk("wrap_unexpected", 64'(1), 64'(0));
                end else begin
                    chk("wrap_rfw", 64'(bus.out_rfw), 64'(exp_rf.pop_front()));
                    chk("wrap_pc",  64'(bus.out_pc),  64'(exp_pc.pop_front()));
                    rcvd++;
                end
            end
            if (sent < 200 && $urandom_range(0, 1) == 1 && bus.in_ready) begin
                r = mk(5'((sent % 31) + 1), $urandom);
                drive('0, '0, r, 32'(32'h3000 + 4 * sent));
                exp_rf.push_back(r);
                exp_pc.push_back(32'(32'h3000 + 4 * sent));
                sent++;
            end else begin
                idle();
            end
            tick();
            cyc++;
        end
        idle();
        bus.out_ready = 1'b0;
        chk("wrap_received", 64'(rcvd),     64'(200));
        chk("wrap_le64",     64'(over64),   64'(0));
        chk("wrap_count",    64'(count),    64'(0));
        chk("wrap_drop",     64'(drop_cnt), 64'(4));

        // writes to $0
        drive(mk(5'd0, 32'h5), 32'h400, mk(5'd3, 32'h7), 32'h404);
        tick();
        idle();
`ifdef RFWQ_SKIP_R0_EN
        chk("r0_count", 64'(count),       64'(1));
        chk("r0_rfw",   64'(bus.out_rfw), 64'(mk(5'd3, 32'h7)));
        chk("r0_pc",    64'(bus.out_pc),  64'(32'h404));
`else
        chk("r0_count", 64'(count),       64'(2));
        chk("r0_rfw",   64'(bus.out_rfw), 64'(mk(5'd0, 32'h5)));
        chk("r0_pc",    64'(bus.out_pc),  64'(32'h400));
`endif
        bus.out_ready = 1'b1;
        guard = 0;
        while (bus.out_valid && guard < 4) begin
            tick();
            guard++;
        end
        bus.out_ready = 1'b0;
        chk("r0_drained", 64'(count), 64'(0));

        // reset mid-operation with count=10
        for (int i = 0; i < 5; i++) begin
            drive(mk(5'd11, 32'(i)), 32'(32'h600 + 8 * i), mk(5'd12, 32'(i)), 32'(32'h604 + 8 * i));
            tick();
        end
        idle();
        chk("pre_rst_count",    64'(count),    64'(10));
        chk("pre_rst_overflow", 64'(overflow), 64'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("midrst_valid",    64'(bus.out_valid), 64'(0));
        chk("midrst_count",    64'(count),         64'(0));
        chk("midrst_overflow", 64'(overflow),      64'(0));
        chk("midrst_drop",     64'(drop_cnt),      64'(0));
        chk("midrst_in_ready", 64'(bus.in_ready),  64'(1));
        chk("midrst_pc",       64'(bus.out_pc),    64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
